// File: rtl/mul_share_rr_arbiter_if.sv
// Request/response bundle for the shared-multiplier arbiter.
// master = requesters plus result consumer; slave = the arbiter itself.
interface mul_share_rr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DIN0_WIDTH = 12,
   parameter int unsigned DIN1_WIDTH = 4,
   parameter int unsigned DOUT_WIDTH = 13
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
   logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [ID_W-1:0]               rsp_id;
   logic [DOUT_WIDTH-1:0]         rsp_dout;

   modport master (
      output req_valid, req_din0, req_din1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_dout
   );

   modport slave (
      input  req_valid, req_din0, req_din1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_dout
   );
endinterface

// File: rtl/mul_share_rr_arbiter.sv
// Round-robin arbiter sharing one signed multiplier between NUM_REQ requesters.
// The product travels down a lockstep NUM_STAGE-deep pipeline tagged with the
// owning requester index; the whole pipeline freezes under output backpressure.
module mul_share_rr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DIN0_WIDTH = 12,
   parameter int unsigned DIN1_WIDTH = 4,
   parameter int unsigned DOUT_WIDTH = 13,
   parameter int unsigned NUM_STAGE  = 2
) (
   input logic                    ap_clk,
   input logic                    ap_rst_n,
   mul_share_rr_arbiter_if.slave  bus
);
   localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PROD_W = DIN0_WIDTH + DIN1_WIDTH;

   logic                         en;
   logic                         grant_any;
   logic [ID_W-1:0]              grant_id;
   logic [NUM_REQ-1:0]           grant;
   logic [ID_W-1:0]              last_q;

   logic [DIN0_WIDTH-1:0]        op0;
   logic [DIN1_WIDTH-1:0]        op1;
   logic signed [PROD_W-1:0]     op0_x;
   logic signed [PROD_W-1:0]     op1_x;
   logic signed [PROD_W-1:0]     prod;

   logic [NUM_STAGE-1:0]         vld_q;
   logic [ID_W-1:0]              id_q  [NUM_STAGE];
   logic [DOUT_WIDTH-1:0]        dat_q [NUM_STAGE];

   // Pipeline advances unless the last stage holds an unconsumed result.
   assign en = !(vld_q[NUM_STAGE-1] && !bus.rsp_ready);

   // Round-robin search: first indices above last, then wrap to 0..last.
   // Reset also suppresses grants so req_ready reads 0 while held in reset.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_any && bus.req_valid[i] && (ID_W'(i) > last_q)) begin
            grant_any = 1'b1;
            grant_id  = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_any && bus.req_valid[i] && (ID_W'(i) <= last_q)) begin
            grant_any = 1'b1;
            grant_id  = ID_W'(i);
         end
      end
      if (!en || !ap_rst_n) begin
         grant_any = 1'b0;
         grant_id  = '0;
      end
   end

   // One-hot grant vector driven back to the requesters.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = grant_any && (grant_id == ID_W'(i));
      end
   end

   assign bus.req_ready = grant;

   // Operand mux: zero operands on a bubble so idle stages carry a zero product.
   always_comb begin
      op0 = '0;
      op1 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            op0 = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
            op1 = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
         end
      end
   end

   // Full-width signed product; only the low DOUT_WIDTH bits are kept (wraps).
   always_comb begin
      op0_x = {{DIN1_WIDTH{op0[DIN0_WIDTH-1]}}, op0};
      op1_x = {{DIN0_WIDTH{op1[DIN1_WIDTH-1]}}, op1};
      prod  = op0_x * op1_x;
   end

   // Pipeline stages and round-robin pointer; everything holds while stalled.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q  <= '0;
         last_q <= ID_W'(NUM_REQ - 1);
         for (int s = 0; s < NUM_STAGE; s++) begin
            id_q[s]  <= '0;
            dat_q[s] <= '0;
         end
      end else if (en) begin
         vld_q[0] <= grant_any;
         id_q[0]  <= grant_id;
         dat_q[0] <= prod[DOUT_WIDTH-1:0];
         for (int s = 1; s < NUM_STAGE; s++) begin
            vld_q[s] <= vld_q[s-1];
            id_q[s]  <= id_q[s-1];
            dat_q[s] <= dat_q[s-1];
         end
         if (grant_any) begin
            last_q <= grant_id;
         end
      end
   end

   assign bus.rsp_valid = vld_q[NUM_STAGE-1];
   assign bus.rsp_id    = id_q[NUM_STAGE-1];
   assign bus.rsp_dout  = dat_q[NUM_STAGE-1];

endmodule

// File: tb/tb_mul_share_rr_arbiter.sv
// Directed bench for mul_share_rr_arbiter with default parameters (4 req, 12x4->13, 2 stages).
module tb_mul_share_rr_arbiter;
   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned DIN0_WIDTH = 12;
   localparam int unsigned DIN1_WIDTH = 4;
   localparam int unsigned DOUT_WIDTH = 13;
   localparam int unsigned NUM_STAGE  = 2;

   logic ap_clk = 1'b0;
   logic ap_rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Hand-computed products for the fairness operand set:
   // 10*1=10, -20*2=-40, 30*-3=-90, -40*-4=160 (13-bit two's complement).
   logic [DOUT_WIDTH-1:0] exp_fair [NUM_REQ];

   mul_share_rr_arbiter_if #(
      .NUM_REQ(NUM_REQ), .DIN0_WIDTH(DIN0_WIDTH),
      .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
   ) bus ();

   mul_share_rr_arbiter #(
      .NUM_REQ(NUM_REQ), .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH),
      .DOUT_WIDTH(DOUT_WIDTH), .NUM_STAGE(NUM_STAGE)
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst_n(ap_rst_n),
      .bus(bus)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [11:0] a, input logic [3:0] b);
      bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH] = a;
      bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH] = b;
   endtask

   task automatic load_fair_ops();
      set_ops(0, 12'd10, 4'd1);
      set_ops(1, 12'hFEC, 4'd2);
      set_ops(2, 12'd30, 4'hD);
      set_ops(3, 12'hFD8, 4'hC);
   endtask

   // Ends at posedge+1 with reset released and no requests pending.
   task automatic do_reset();
      ap_rst_n = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge ap_clk);
      #3 ap_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      bus.req_valid = 4'hF;
      bus.rsp_ready = 1'b1;
      load_fair_ops();
      repeat (2) @(posedge ap_clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_id !== 2'd0) begin
         failures++; $display("FAIL reset_rsp_id got=%0d want=0", bus.rsp_id);
      end
      checks++;
      if (bus.rsp_dout !== 13'd0) begin
         failures++; $display("FAIL reset_rsp_dout got=%h want=0", bus.rsp_dout);
      end
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         failures++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready);
      end
      #2 ap_rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++; $display("FAIL reset_first_grant got=%b want=0001", bus.req_ready);
      end
      bus.req_valid = '0;
      tick();
   endtask

   task automatic test_single_op();
      do_reset();
      set_ops(0, 12'd100, 4'hD);
      bus.req_valid = 4'b0001;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++; $display("FAIL single_ready got=%b want=0001", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL single_early_valid got=%b want=0", bus.rsp_valid);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_dout !== 13'h1ED4) begin
         failures++;
         $display("FAIL single_result got v=%b id=%0d d=%h want v=1 id=0 d=1ed4",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL single_no_dup got=%b want=0", bus.rsp_valid);
      end
   endtask

   task automatic test_truncation();
      do_reset();
      set_ops(2, 12'h7FF, 4'd7);
      bus.req_valid = 4'b0100;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         failures++; $display("FAIL trunc_ready got=%b want=0100", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_dout !== 13'h17F9) begin
         failures++;
         $display("FAIL trunc_result got v=%b id=%0d d=%h want v=1 id=2 d=17f9",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] want_rdy;
      do_reset();
      load_fair_ops();
      for (int c = 0; c < 10; c++) begin
         bus.req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         want_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
         checks++;
         if (bus.req_ready !== want_rdy) begin
            failures++;
            $display("FAIL fair_grant c=%0d got=%b want=%b", c, bus.req_ready, want_rdy);
         end
         tick();
         checks++;
         if (c >= 1 && c <= 8) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((c - 1) % 4) ||
                bus.rsp_dout !== exp_fair[(c - 1) % 4]) begin
               failures++;
               $display("FAIL fair_rsp c=%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_dout, (c - 1) % 4,
                        exp_fair[(c - 1) % 4]);
            end
         end else if (bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL fair_idle c=%0d got v=%b want 0", c, bus.rsp_valid);
         end
      end
   endtask

   task automatic test_sparse();
      logic [3:0] want_rdy;
      do_reset();
      load_fair_ops();
      bus.req_valid = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         #1;
         want_rdy = (c % 2 == 0) ? 4'b0010 : 4'b1000;
         checks++;
         if (bus.req_ready !== want_rdy) begin
            failures++;
            $display("FAIL sparse_grant c=%0d got=%b want=%b", c, bus.req_ready, want_rdy);
         end
         tick();
         if (c >= 1) begin
            checks++;
            if (bus.rsp_id !== (((c - 1) % 2 == 0) ? 2'd1 : 2'd3)) begin
               failures++; $display("FAIL sparse_rsp_id c=%0d got=%0d", c, bus.rsp_id);
            end
         end
      end
      bus.req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_single_requester();
      do_reset();
      load_fair_ops();
      bus.req_valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL solo_grant c=%0d got=%b want=0100", c, bus.req_ready);
         end
         tick();
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_dout !== 13'h1FA6) begin
         failures++;
         $display("FAIL solo_rsp got v=%b id=%0d d=%h want v=1 id=2 d=1fa6",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
      end
      bus.req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      load_fair_ops();
      bus.req_valid = 4'hF;
      tick();
      tick();
      bus.rsp_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 ||
             bus.rsp_dout !== 13'h000A) begin
            failures++;
            $display("FAIL stall_hold c=%0d got rdy=%b v=%b id=%0d d=%h want 0000 1 0 000a",
                     c, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
         end
         if (c < 3) tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         failures++; $display("FAIL stall_resume_grant got=%b want=0100", bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_dout !== 13'h1FD8) begin
         failures++;
         $display("FAIL drain1 got v=%b id=%0d d=%h want v=1 id=1 d=1fd8",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_dout !== 13'h1FA6) begin
         failures++;
         $display("FAIL drain2 got v=%b id=%0d d=%h want v=1 id=2 d=1fa6",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL drain_empty got v=%b want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      load_fair_ops();
      bus.req_valid = 4'hF;
      tick();
      tick();
      #2 ap_rst_n = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_dout !== 13'd0 ||
          bus.req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL async_clear got v=%b id=%0d d=%h rdy=%b want 0 0 0000 0000",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_dout, bus.req_ready);
      end
      @(posedge ap_clk);
      #3 ap_rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++; $display("FAIL async_first_grant got=%b want=0001", bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL async_stale got v=%b want 0", bus.rsp_valid);
      end
      tick();
      bus.req_valid = '0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_dout !== 13'h000A) begin
         failures++;
         $display("FAIL async_first_rsp got v=%b id=%0d d=%h want v=1 id=0 d=000a",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_dout);
      end
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_fair[0] = 13'h000A;
      exp_fair[1] = 13'h1FD8;
      exp_fair[2] = 13'h1FA6;
      exp_fair[3] = 13'h00A0;
      bus.req_valid = '0;
      bus.req_din0  = '0;
      bus.req_din1  = '0;
      bus.rsp_ready = 1'b1;
      test_reset();
      test_single_op();
      test_truncation();
      test_fairness();
      test_sparse();
      test_single_requester();
      test_backpressure();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
